lap_stack_ctrl: RTL and testbench

//  Controller sequencing the lap-count LIFO (12-bit entries, push/pop strobes, top-of-stack read).

---
 rtl/lap_stack_ctrl.sv | 134 +++++++++++++
 tb/tb_lap_stack_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_stack_ctrl.sv
// Lap-stack sequencer: turns lap/recall/clear strobes into single push/pop pulses
// for the lap LIFO, tracks occupancy and latches the recalled lap for display.
module lap_stack_ctrl #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 12,
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             lap_req,
    input  logic             recall_req,
    input  logic             clear_req,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_write,
    output logic             mem_read,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] shown,
    output logic             shown_valid,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             drop
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, DRAIN} state_t;

    state_t           state_q, state_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q, mem_read_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [WIDTH-1:0] shown_q, shown_d;
    logic             shown_valid_q, shown_valid_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic             is_full, is_empty;

    assign is_full  = (level_q == LVL_W'(DEPTH));
    assign is_empty = (level_q == '0);

    always_comb begin
        state_d       = IDLE;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        shown_d       = shown_q;
        shown_valid_d = shown_valid_q;
        level_d       = level_q;
        busy_d        = 1'b0;
        drop_d        = 1'b0;

        // The pop completes first so a clear accepted on the same edge still wins.
        if (state_q == POP) begin
            shown_d       = mem_rdata;
            shown_valid_d = 1'b1;
        end

        if (state_q == DRAIN) begin
            drop_d = lap_req | recall_req | clear_req;
            if (level_q <= LVL_W'(1)) begin
                level_d = '0;
                state_d = IDLE;
            end else begin
                level_d    = level_q - LVL_W'(1);
                state_d    = DRAIN;
                mem_read_d = 1'b1;
                busy_d     = 1'b1;
            end
        end else if (clear_req) begin
            shown_d       = '0;
            shown_valid_d = 1'b0;
            if (!is_empty) begin
                state_d    = DRAIN;
                mem_read_d = 1'b1;
                busy_d     = 1'b1;
            end
        end else if (recall_req) begin
            if (is_empty) begin
                drop_d = 1'b1;
            end else begin
                state_d    = POP;
                level_d    = level_q - LVL_W'(1);
                mem_read_d = 1'b1;
            end
        end else if (lap_req) begin
            if (is_full) begin
                drop_d = 1'b1;
            end else begin
                state_d     = PUSH;
                level_d     = level_q + LVL_W'(1);
                mem_write_d = 1'b1;
                mem_wdata_d = count_in;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_wdata_q   <= '0;
            shown_q       <= '0;
            shown_valid_q <= 1'b0;
            level_q       <= '0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_wdata_q   <= mem_wdata_d;
            shown_q       <= shown_d;
            shown_valid_q <= shown_valid_d;
            level_q       <= level_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign mem_wdata   = mem_wdata_q;
    assign shown       = shown_q;
    assign shown_valid = shown_valid_q;
    assign level       = level_q;
    assign full        = is_full;
    assign empty       = is_empty;
    assign busy        = busy_q;
    assign drop        = drop_q;

endmodule

// File: tb/tb_lap_stack_ctrl.sv
// Directed bench for lap_stack_ctrl with a small behavioural LIFO behind the
// memory port; expected values are hand-computed constants.
module tb_lap_stack_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        lap_req = 1'b0;
    logic        recall_req = 1'b0;
    logic        clear_req = 1'b0;
    logic [11:0] count_in = '0;
    logic [11:0] mem_rdata;
    logic        mem_write, mem_read;
    logic [11:0] mem_wdata, shown;
    logic        shown_valid;
    logic [2:0]  level;
    logic        full, empty, busy, drop;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_base, rd_base;

    logic [11:0] stk [0:4];
    int          sp;

    always #5 clk = ~clk;

    lap_stack_ctrl #(.DEPTH(5), .WIDTH(12), .LVL_W(3)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .lap_req     (lap_req),
        .recall_req  (recall_req),
        .clear_req   (clear_req),
        .count_in    (count_in),
        .mem_rdata   (mem_rdata),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_wdata   (mem_wdata),
        .shown       (shown),
        .shown_valid (shown_valid),
        .level       (level),
        .full        (full),
        .empty       (empty),
        .busy        (busy),
        .drop        (drop)
    );

    // Behavioural lap stack sharing the controller's reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sp <= 0;
        end else if (mem_write && sp < 5) begin
            stk[sp] <= mem_wdata;
            sp      <= sp + 1;
        end else if (mem_read && sp > 0) begin
            sp <= sp - 1;
        end
    end

    assign mem_rdata = (sp == 0) ? 12'h000 : stk[sp-1];

    always @(posedge clk) begin
        if (mem_write) wr_cnt++;
        if (mem_read)  rd_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        // Reset values
        step();
        check_output("rst_level", level, 0);
        check_output("rst_empty", empty, 1);
        check_output("rst_full", full, 0);
        check_output("rst_shown", shown, 0);
        check_output("rst_valid", shown_valid, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_drop", drop, 0);
        check_output("rst_wr", mem_write, 0);
        check_output("rst_rd", mem_read, 0);
        check_output("rst_wdata", mem_wdata, 0);
        nrst = 1'b1;
        step();

        // 1: five laps fill the stack, sixth is dropped
        wr_base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            count_in = 12'(10 * (i + 1));
            lap_req = 1'b1;
            step();
            lap_req = 1'b0;
            check_output("t1_write", mem_write, 1);
            check_output("t1_wdata", mem_wdata, 10 * (i + 1));
            check_output("t1_level", level, i + 1);
            step();
            check_output("t1_write_off", mem_write, 0);
        end
        check_output("t1_full", full, 1);
        check_output("t1_wr_cnt", wr_cnt - wr_base, 5);
        count_in = 12'd60;
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        check_output("t1_drop", drop, 1);
        check_output("t1_drop_nowr", mem_write, 0);
        check_output("t1_drop_level", level, 5);
        step();
        check_output("t1_drop_pulse", drop, 0);
        check_output("t1_wr_cnt2", wr_cnt - wr_base, 5);

        // 2: three recalls return 30, 20, 10; fourth is dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            count_in = 12'(10 * (i + 1));
            lap_req = 1'b1;
            step();
        end
        lap_req = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            recall_req = 1'b1;
            step();
            recall_req = 1'b0;
            check_output("t2_read", mem_read, 1);
            check_output("t2_level", level, 2 - i);
            step();
            check_output("t2_shown", shown, 30 - 10 * i);
            check_output("t2_valid", shown_valid, 1);
            check_output("t2_read_off", mem_read, 0);
        end
        check_output("t2_empty", empty, 1);
        recall_req = 1'b1;
        step();
        recall_req = 1'b0;
        check_output("t2_drop", drop, 1);
        check_output("t2_drop_nord", mem_read, 0);
        step();
        check_output("t2_keep_shown", shown, 10);
        check_output("t2_keep_valid", shown_valid, 1);

        // 3: clear with four entries drains in four cycles; lap mid-drain dropped
        lap_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            count_in = 12'(i + 1);
            step();
        end
        lap_req = 1'b0;
        check_output("t3_level4", level, 4);
        step();
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_output("t3_busy0", busy, 1);
        check_output("t3_read0", mem_read, 1);
        check_output("t3_level0", level, 4);
        check_output("t3_shown", shown, 0);
        check_output("t3_valid", shown_valid, 0);
        step();
        check_output("t3_level1", level, 3);
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        check_output("t3_drop", drop, 1);
        check_output("t3_nowr", mem_write, 0);
        check_output("t3_level2", level, 2);
        step();
        check_output("t3_busy3", busy, 1);
        check_output("t3_level3", level, 1);
        step();
        check_output("t3_busy_end", busy, 0);
        check_output("t3_read_end", mem_read, 0);
        check_output("t3_level_end", level, 0);
        check_output("t3_empty", empty, 1);
        check_output("t3_rd_cnt", rd_cnt - rd_base, 4);
        check_output("t3_wr_cnt", wr_cnt - wr_base, 0);

        // 4: priority resolution
        lap_req = 1'b1;
        count_in = 12'h011;
        step();
        count_in = 12'h022;
        step();
        lap_req = 1'b0;
        step();
        lap_req = 1'b1;
        recall_req = 1'b1;
        clear_req = 1'b1;
        step();
        lap_req = 1'b0;
        recall_req = 1'b0;
        clear_req = 1'b0;
        check_output("t4_busy", busy, 1);
        check_output("t4_drop", drop, 0);
        check_output("t4_nowr", mem_write, 0);
        check_output("t4_level", level, 2);
        step();
        step();
        check_output("t4_drained", level, 0);
        check_output("t4_idle", busy, 0);
        lap_req = 1'b1;
        count_in = 12'h033;
        step();
        count_in = 12'h044;
        step();
        lap_req = 1'b0;
        step();
        lap_req = 1'b1;
        recall_req = 1'b1;
        step();
        lap_req = 1'b0;
        recall_req = 1'b0;
        check_output("t4_pop_rd", mem_read, 1);
        check_output("t4_pop_nowr", mem_write, 0);
        check_output("t4_pop_level", level, 1);
        step();
        check_output("t4_pop_shown", shown, 12'h044);

        // 5: push then pop on consecutive cycles
        count_in = 12'h5A5;
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        recall_req = 1'b1;
        check_output("t5_write", mem_write, 1);
        check_output("t5_level_up", level, 2);
        step();
        recall_req = 1'b0;
        check_output("t5_read", mem_read, 1);
        check_output("t5_write_off", mem_write, 0);
        check_output("t5_level_back", level, 1);
        step();
        check_output("t5_shown", shown, 12'h5A5);
        check_output("t5_read_off", mem_read, 0);

        // 6: async reset in the middle of a three-entry drain
        lap_req = 1'b1;
        count_in = 12'h0AA;
        step();
        count_in = 12'h0BB;
        step();
        lap_req = 1'b0;
        step();
        check_output("t6_level3", level, 3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        check_output("t6_busy", busy, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_output("t6_rst_level", level, 0);
        check_output("t6_rst_busy", busy, 0);
        check_output("t6_rst_rd", mem_read, 0);
        check_output("t6_rst_empty", empty, 1);
        check_output("t6_rst_wdata", mem_wdata, 0);
        step();
        nrst = 1'b1;
        count_in = 12'h123;
        lap_req = 1'b1;
        step();
        lap_req = 1'b0;
        check_output("t6_lap_write", mem_write, 1);
        check_output("t6_lap_level", level, 1);
        step();
        check_output("t6_lap_level2", level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
